// File: rtl/pc_unit_if.sv
// Decoder/fetch-side bundle for pc_unit: control-flow request in, PC and RAS status out.
interface pc_unit_if #(
   parameter int unsigned PC_W      = 16,
   parameter int unsigned OFF_W     = 8,
   parameter int unsigned RAS_DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [2:0]       kind;
   logic             z;
   logic             neg;
   logic [OFF_W-1:0] offset;
   logic [PC_W-1:0]  target;
   logic             stall;
   logic             start;

   logic [PC_W-1:0]  pc;
   logic             halted;
   logic             taken;
   logic [CNT_W-1:0] ras_cnt;
   logic             ras_ovf;
   logic             ras_unf;

   modport master (
      output kind, z, neg, offset, target, stall, start,
      input  pc, halted, taken, ras_cnt, ras_ovf, ras_unf
   );

   modport slave (
      input  kind, z, neg, offset, target, stall, start,
      output pc, halted, taken, ras_cnt, ras_ovf, ras_unf
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter with relative/absolute jumps, CALL/RET via a circular
// return-address stack, stall, and halt/restart control.
module pc_unit #(
   parameter int unsigned PC_W       = 16,
   parameter int unsigned OFF_W      = 8,
   parameter int unsigned RAS_DEPTH  = 4,
   parameter int unsigned START_ADDR = 0
) (
   input logic      clk,
   input logic      reset,
   pc_unit_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

   localparam logic [2:0] K_NONE = 3'd0;
   localparam logic [2:0] K_BRZ  = 3'd1;
   localparam logic [2:0] K_BRN  = 3'd2;
   localparam logic [2:0] K_JMP  = 3'd3;
   localparam logic [2:0] K_JABS = 3'd4;
   localparam logic [2:0] K_CALL = 3'd5;
   localparam logic [2:0] K_RET  = 3'd6;
   localparam logic [2:0] K_HALT = 3'd7;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  pc_inc, pc_rel, off_sext;
   logic [PC_W-1:0]  ras_q [RAS_DEPTH];
   logic [PTR_W-1:0] sp_q, sp_d, sp_inc, sp_dec;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             push;
   logic             taken_c;

   assign off_sext = PC_W'($signed(bus.offset));
   assign pc_inc   = pc_q + PC_W'(1);
   assign pc_rel   = pc_q + off_sext;

   // sp_q points at the slot the next push writes; wrap explicitly so any depth works
   assign sp_inc = (sp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp_q + PTR_W'(1);
   assign sp_dec = (sp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : sp_q - PTR_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RUN;
         pc_q    <= PC_W'(START_ADDR);
         sp_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage carries no reset; only the count defines which entries are valid
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         ras_q[sp_q] <= pc_inc;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      taken_c = 1'b0;

      unique case (state_q)
         S_RUN: begin
            if (!bus.stall) begin
               pc_d = pc_inc;
               unique case (bus.kind)
                  K_NONE: ;
                  K_BRZ: begin
                     if (bus.z) begin
                        pc_d    = pc_rel;
                        taken_c = 1'b1;
                     end
                  end
                  K_BRN: begin
                     if (bus.neg) begin
                        pc_d    = pc_rel;
                        taken_c = 1'b1;
                     end
                  end
                  K_JMP: begin
                     pc_d    = pc_rel;
                     taken_c = 1'b1;
                  end
                  K_JABS: begin
                     pc_d    = bus.target;
                     taken_c = 1'b1;
                  end
                  K_CALL: begin
                     // A full stack overwrites its oldest slot, which is the one sp_q points at
                     push    = 1'b1;
                     pc_d    = pc_rel;
                     taken_c = 1'b1;
                     sp_d    = sp_inc;
                     if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                        ovf_d = 1'b1;
                     end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end
                  K_RET: begin
                     if (cnt_q != '0) begin
                        pc_d    = ras_q[sp_dec];
                        sp_d    = sp_dec;
                        cnt_d   = cnt_q - CNT_W'(1);
                        taken_c = 1'b1;
                     end else begin
                        unf_d = 1'b1;
                     end
                  end
                  K_HALT: begin
                     pc_d    = pc_q;
                     state_d = S_HALT;
                  end
               endcase
            end
         end
         S_HALT: begin
            if (bus.start) begin
               pc_d    = PC_W'(START_ADDR);
               state_d = S_RUN;
            end
         end
      endcase
   end

   assign bus.pc      = pc_q;
   assign bus.halted  = (state_q == S_HALT);
   assign bus.taken   = taken_c;
   assign bus.ras_cnt = cnt_q;
   assign bus.ras_ovf = ovf_q;
   assign bus.ras_unf = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a queue-based reference model.
module tb_pc_unit;
   localparam int unsigned DEPTH = 4;

   logic clk;
   logic reset;

   pc_unit_if #(.PC_W(16), .OFF_W(8), .RAS_DEPTH(DEPTH)) bus ();

   pc_unit #(
      .PC_W(16), .OFF_W(8), .RAS_DEPTH(DEPTH), .START_ADDR(0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: return addresses live in a queue, newest at the back
   logic [15:0] m_pc;
   bit          m_halt;
   bit          m_ovf;
   bit          m_unf;
   bit          m_valid = 1'b0;
   logic [15:0] ras [$];
   logic        last_taken;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
   endtask

   function automatic bit exp_taken();
      if (m_halt || bus.stall) return 1'b0;
      case (bus.kind)
         3'd1:    return bus.z;
         3'd2:    return bus.neg;
         3'd3, 3'd4, 3'd5: return 1'b1;
         3'd6:    return ras.size() > 0;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin
      int soff;
      soff = $signed(bus.offset);
      if (reset) begin
         m_pc    = 16'h0000;
         m_halt  = 1'b0;
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
         m_valid = 1'b1;
         ras.delete();
      end else if (m_valid) begin
         if (m_halt) begin
            if (bus.start) begin
               m_pc   = 16'h0000;
               m_halt = 1'b0;
            end
         end else if (!bus.stall) begin
            case (bus.kind)
               3'd0: m_pc = m_pc + 16'd1;
               3'd1: m_pc = bus.z   ? m_pc + 16'(soff) : m_pc + 16'd1;
               3'd2: m_pc = bus.neg ? m_pc + 16'(soff) : m_pc + 16'd1;
               3'd3: m_pc = m_pc + 16'(soff);
               3'd4: m_pc = bus.target;
               3'd5: begin
                  if (ras.size() == DEPTH) begin
                     void'(ras.pop_front());
                     m_ovf = 1'b1;
                  end
                  ras.push_back(m_pc + 16'd1);
                  m_pc = m_pc + 16'(soff);
               end
               3'd6: begin
                  if (ras.size() > 0) m_pc = ras.pop_back();
                  else begin
                     m_pc  = m_pc + 16'd1;
                     m_unf = 1'b1;
                  end
               end
               default: m_halt = 1'b1;
            endcase
         end
      end
   end

   // Compare process: state outputs and combinational taken, mid-cycle
   always @(negedge clk) begin
      if (m_valid) begin
         chk("pc",      32'(bus.pc),      32'(m_pc));
         chk("halted",  32'(bus.halted),  32'(m_halt));
         chk("ras_cnt", 32'(bus.ras_cnt), ras.size());
         chk("ras_ovf", 32'(bus.ras_ovf), 32'(m_ovf));
         chk("ras_unf", 32'(bus.ras_unf), 32'(m_unf));
         chk("taken",   32'(bus.taken),   32'(exp_taken()));
      end
   end

   task automatic cyc(input logic [2:0] k, input logic [7:0] off = 8'h00,
                      input logic [15:0] tgt = 16'h0000, input logic zz = 1'b0,
                      input logic nn = 1'b0, input logic st = 1'b0, input logic go = 1'b0);
      bus.kind   = k;
      bus.offset = off;
      bus.target = tgt;
      bus.z      = zz;
      bus.neg    = nn;
      bus.stall  = st;
      bus.start  = go;
      #1 last_taken = bus.taken;
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b1;
      cyc(3'd0);
      cyc(3'd0);
      reset = 1'b0;
      chk("lit_reset_pc", 32'(bus.pc), 32'h0);
      chk("lit_reset_halted", 32'(bus.halted), 32'h0);
      chk("lit_reset_cnt", 32'(bus.ras_cnt), 32'h0);
      for (int i = 1; i <= 4; i++) begin
         cyc(3'd0);
         chk("lit_seq_pc", 32'(bus.pc), 32'(i));
      end

      // Branches
      cyc(3'd4, 8'h00, 16'h0010);
      cyc(3'd1, 8'hFD, 16'h0000, 1'b1);
      chk("lit_brz_taken_pc", 32'(bus.pc), 32'h000D);
      chk("lit_brz_taken", 32'(last_taken), 32'h1);
      cyc(3'd4, 8'h00, 16'h0010);
      cyc(3'd1, 8'hFD, 16'h0000, 1'b0);
      chk("lit_brz_not_pc", 32'(bus.pc), 32'h0011);
      chk("lit_brz_not_taken", 32'(last_taken), 32'h0);
      cyc(3'd2, 8'h05, 16'h0000, 1'b0, 1'b1);
      chk("lit_brn_pc", 32'(bus.pc), 32'h0016);

      // Wrap and absolute
      cyc(3'd4, 8'h00, 16'hFFFF);
      cyc(3'd0);
      chk("lit_wrap_pc", 32'(bus.pc), 32'h0000);
      cyc(3'd4, 8'h00, 16'h1234);
      chk("lit_jabs_pc", 32'(bus.pc), 32'h1234);
      cyc(3'd4, 8'h00, 16'h0002);
      cyc(3'd3, 8'hFC);
      chk("lit_jmp_neg_pc", 32'(bus.pc), 32'hFFFE);

      // RAS nominal
      cyc(3'd4, 8'h00, 16'h0020);
      cyc(3'd5, 8'h10);
      chk("lit_call_pc", 32'(bus.pc), 32'h0030);
      chk("lit_call_cnt", 32'(bus.ras_cnt), 32'h1);
      cyc(3'd6);
      chk("lit_ret_pc", 32'(bus.pc), 32'h0021);
      chk("lit_ret_cnt", 32'(bus.ras_cnt), 32'h0);
      chk("lit_ret_flags", {30'h0, bus.ras_ovf, bus.ras_unf}, 32'h0);

      // RAS overflow then underflow
      cyc(3'd4, 8'h00, 16'h0100);
      for (int i = 0; i < 5; i++) cyc(3'd5, 8'h10);
      chk("lit_ovf_flag", 32'(bus.ras_ovf), 32'h1);
      chk("lit_ovf_cnt", 32'(bus.ras_cnt), 32'h4);
      for (int i = 0; i < 4; i++) begin
         cyc(3'd6);
         chk("lit_unwind_pc", 32'(bus.pc), 32'h0141 - 32'(i) * 32'h10);
      end
      cyc(3'd6);
      chk("lit_unf_pc", 32'(bus.pc), 32'h0112);
      chk("lit_unf_flag", 32'(bus.ras_unf), 32'h1);

      // Stall and halt
      cyc(3'd5, 8'h10, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("lit_stall_pc", 32'(bus.pc), 32'h0112);
      chk("lit_stall_cnt", 32'(bus.ras_cnt), 32'h0);
      chk("lit_stall_taken", 32'(last_taken), 32'h0);
      cyc(3'd7);
      for (int i = 0; i < 5; i++) begin
         cyc(3'($urandom_range(7)), 8'($urandom), 16'($urandom), 1'b1, 1'b1);
         chk("lit_halt_pc", 32'(bus.pc), 32'h0112);
         chk("lit_halt_flag", 32'(bus.halted), 32'h1);
      end
      cyc(3'd0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lit_restart_pc", 32'(bus.pc), 32'h0000);
      chk("lit_restart_halted", 32'(bus.halted), 32'h0);
      chk("lit_restart_flags", {30'h0, bus.ras_ovf, bus.ras_unf}, 32'h3);
      cyc(3'd7);
      reset = 1'b1;
      cyc(3'd0);
      reset = 1'b0;
      chk("lit_halt_reset_pc", 32'(bus.pc), 32'h0000);
      chk("lit_halt_reset_halted", 32'(bus.halted), 32'h0);
      chk("lit_halt_reset_flags", {30'h0, bus.ras_ovf, bus.ras_unf}, 32'h0);

      // Random phase, checked by the compare process
      for (int i = 0; i < 4000; i++) begin
         logic [2:0] k;
         k = ($urandom_range(15) == 0) ? 3'd7 : 3'($urandom_range(6));
         reset = ($urandom_range(199) == 0);
         cyc(k, 8'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(4) == 0), ($urandom_range(2) == 0));
      end
      reset = 1'b0;
      cyc(3'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the in-class CPU family. It generalises the basic PC in three ways: configurable PC/offset widths, an absolute jump, and CALL/RET through a hardware return-address stack (RAS). It also adds stall and halt/restart control. It sits between the decoder (which supplies `kind`) and instruction memory (which consumes `pc`).

Parameters:
- PC_W, 16: PC width in bits. Arithmetic is modulo 2^PC_W.
- OFF_W, 8: width of the signed relative offset.
- RAS_DEPTH, 4: number of return-address stack entries. Must be ≥ 2.
- START_ADDR, 0: PC value after reset or restart.

Ports:
- clk: input, 1. Clock. PC, RAS and flags all update on posedge.
- reset: input, 1. Synchronous, active-high. Overrides all other inputs.
- kind: input, 3. Control-flow kind:
  - 0 NONE, 1 BRZ, 2 BRN, 3 JMP (relative), 4 JABS (absolute)
  - 5 CALL (relative, push), 6 RET (pop), 7 HALT
- z: input, 1. ALU zero flag.
- neg: input, 1. ALU negative flag.
- offset: input, OFF_W. Signed relative displacement.
- target: input, PC_W. Absolute target for JABS.
- stall: input, 1. Freezes PC and RAS while in RUN.
- start: input, 1. Restart pulse, honoured only in HALT.
- pc: output, PC_W. Current program counter.
- halted: output, 1. High in HALT state.
- taken: output, 1. Combinational; high when the next PC is a redirect (not pc+1) in this cycle.
- ras_cnt: output, $clog2(RAS_DEPTH+1). Number of valid RAS entries.
- ras_ovf: output, 1. Sticky flag: CALL was issued with the RAS full.
- ras_unf: output, 1. Sticky flag: RET was issued with the RAS empty.

Behaviour:
- Reset:
  - pc = START_ADDR, state = RUN, halted = 0.
  - ras_cnt = 0, ras_ovf = 0, ras_unf = 0. RAS contents are don't-care.
- States:
  - RUN → HALT on kind = HALT while not stalled.
  - HALT → RUN on start = 1.
  - All other inputs are ignored in HALT.
- RUN with stall = 1: pc, RAS, ras_cnt and flags hold; taken = 0; kind ignored.
- RUN with stall = 0, next pc by kind:
  - NONE: pc + 1.
  - BRZ: pc + sext(offset) if z, else pc + 1.
  - BRN: pc + sext(offset) if neg, else pc + 1.
  - JMP: pc + sext(offset).
  - JABS: target.
  - CALL: push (pc + 1), then pc + sext(offset).
  - RET:
    - ras_cnt > 0: pop the top entry → pc; ras_cnt decrements.
    - ras_cnt = 0: pc + 1 and ras_unf ← 1.
  - HALT: pc holds, state → HALT, taken = 0.
- Arithmetic:
  - offset is sign-extended to PC_W before the add.
  - All adds wrap modulo 2^PC_W, e.g. with PC_W = 16, 0xFFFF + 1 = 0x0000, and 0x0002 + (−4) = 0xFFFE.
  - offset = 0 on a taken branch re-executes the same pc (legal self-loop).
- RAS:
  - Circular LIFO.
  - CALL when ras_cnt = RAS_DEPTH overwrites the oldest entry; ras_cnt stays at RAS_DEPTH and ras_ovf ← 1. The newest RAS_DEPTH return addresses are retained.
- Flags: ras_ovf and ras_unf clear only on reset.
- taken: 1 for a taken BRZ/BRN, JMP, JABS, CALL, or a RET with ras_cnt > 0. Otherwise 0.
- HALT restart:
  - start = 1 gives pc ← START_ADDR, state → RUN, halted ← 0 next cycle.
  - RAS contents, ras_cnt and flags are preserved across the restart.
- Simultaneous events:
  - reset wins over everything.
  - stall and start are both live only in their own state, so no conflict arises.
- Reset mid-CALL or mid-RET: the push or pop is discarded; post-reset values as listed under Reset.
- Latency: every update takes effect on the clock edge after the inputs are presented. pc is registered.

Test Plan:
- Reset and sequencing: assert reset 2 cycles, then kind = NONE for 4 cycles → pc goes 0, 1, 2, 3, 4; halted = 0; ras_cnt = 0.
- Branches: pc = 0x0010 with BRZ, offset = −3, z = 1 → pc = 0x000D and taken = 1. Same with z = 0 → pc = 0x0011 and taken = 0. BRN with neg = 1, offset = +5 → pc + 5.
- Wrap and absolute: at pc = 0xFFFF, NONE → 0x0000. JABS with target = 0x1234 → 0x1234. pc = 0x0002, JMP, offset = −4 → 0xFFFE.
- RAS nominal: at pc = 0x20, CALL offset = +0x10 → pc = 0x30, ras_cnt = 1. RET → pc = 0x21, ras_cnt = 0, no flags set.
- RAS boundaries (RAS_DEPTH = 4): 5 nested CALLs → ras_ovf = 1, ras_cnt = 4; 4 RETs return the 4 newest addresses in reverse order. A 5th RET → pc + 1, ras_unf = 1.
- Stall and halt: stall = 1 during a CALL → pc and ras_cnt unchanged. kind = HALT → pc holds for 5 cycles with halted = 1 while random kind is driven. start pulse → pc = START_ADDR, halted = 0. reset asserted while halted → pc = START_ADDR, halted = 0, flags cleared.
